// File: rtl/mem_bus_if.sv
`default_nettype none
// ============================================================================
// mem_bus_if : request/response signals of the 64-bit peripheral bus seen by
//              a memory node
// Revision   : 1.0
// ============================================================================
interface mem_bus_if;
  logic [63:0] i_bus;
  logic        o_vld;
  logic [63:0] o_bus;
  logic        bus_gnt;

  modport slave  (input  i_bus, bus_gnt, output o_vld, o_bus);
  modport master (output i_bus, bus_gnt, input  o_vld, o_bus);
endinterface
`default_nettype wire

// File: rtl/mem_bus_target.sv
`default_nettype none
// ============================================================================
// mem_bus_target : memory-side bus responder; two-beat writes into a byte RAM,
//                  single-beat reads answered after a fixed latency
// Revision       : 1.0
// ============================================================================
module mem_bus_target #(
  parameter logic [1:0]  MY_ID     = 2'b11,
  parameter logic [14:0] MEM_BASE  = 15'h0000,
  parameter int          MEM_BYTES = 4096,
  parameter int          RD_LAT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  mem_bus_if.slave    bus,
  output logic        o_busy,
  output logic [15:0] o_wr_cnt,
  output logic [7:0]  o_drop_cnt
);

  localparam int          AW     = $clog2(MEM_BYTES);
  localparam logic [16:0] WIN_LO = {2'b00, MEM_BASE};

  typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RRESP} state_t;

  state_t      state;
  logic [14:0] lat_addr;
  logic [2:0]  lat_size;
  logic [1:0]  lat_src;
  logic [3:0]  lat_cnt;
  logic        resp_vld;
  logic [63:0] resp_bus;
  logic [15:0] wr_cnt;
  logic [7:0]  drop_cnt;

  logic [7:0]  mem [MEM_BYTES];

  logic [31:0] in_data;
  logic [14:0] in_addr;
  logic [2:0]  in_size;
  logic        in_first;
  logic [1:0]  in_rdwr;
  logic [1:0]  in_dst;
  logic [1:0]  in_src;
  logic        in_vld;
  logic        unused_fields;

  assign in_data       = bus.i_bus[31:0];
  assign in_addr       = bus.i_bus[46:32];
  assign in_size       = bus.i_bus[49:47];
  assign in_first      = bus.i_bus[51];
  assign in_rdwr       = bus.i_bus[54:53];
  assign in_dst        = bus.i_bus[56:55];
  assign in_src        = bus.i_bus[58:57];
  assign in_vld        = bus.i_bus[59];
  assign unused_fields = ^{bus.i_bus[63:60], bus.i_bus[52], bus.i_bus[50]};

  logic ours, is_wr, is_rd, take_hdr, data_beat, drop_beat;

  always_comb begin
    ours      = in_vld && (in_dst == MY_ID);
    is_wr     = in_rdwr[1];
    is_rd     = (in_rdwr == 2'b01);
    take_hdr  = ours && in_first &&
                (state == IDLE || (state == WDATA && in_src == lat_src));
    data_beat = ours && !in_first && state == WDATA && in_src == lat_src;
    drop_beat = ours && !data_beat && !(take_hdr && state == IDLE);
  end

  // Per-lane window decode; a lane below the window wraps to a huge offset.
  logic [16:0]   lane_addr [8];
  logic [16:0]   lane_off  [8];
  logic          lane_ok   [8];
  logic [AW-1:0] lane_idx  [8];
  logic [31:0]   rd_data;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      lane_addr[i] = {2'b00, lat_addr} + 17'(i);
      lane_off[i]  = lane_addr[i] - WIN_LO;
      lane_ok[i]   = !lane_addr[i][15] && (lane_off[i] < 17'(MEM_BYTES));
      lane_idx[i]  = lane_off[i][AW-1:0];
    end
    for (int j = 0; j < 4; j++) begin
      rd_data[8*j +: 8] = lane_ok[j] ? mem[lane_idx[j]] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && data_beat) begin
      for (int i = 0; i < 8; i++) begin
        if (3'(i) <= lat_size && lane_ok[i]) begin
          mem[lane_idx[i]] <= in_data[8*(i%4) +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_size <= '0;
      lat_src  <= '0;
      lat_cnt  <= '0;
      resp_vld <= 1'b0;
      resp_bus <= '0;
      wr_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (drop_beat && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state)
        IDLE, WDATA: begin
          if (take_hdr) begin
            if (is_wr || is_rd) begin
              lat_addr <= in_addr;
              lat_size <= in_size;
              lat_src  <= in_src;
            end
            if (is_wr) begin
              state <= WDATA;
            end else if (is_rd) begin
              lat_cnt <= 4'(RD_LAT);
              state   <= RWAIT;
            end else begin
              state <= IDLE;
            end
          end else if (data_beat) begin
            wr_cnt <= wr_cnt + 16'd1;
            state  <= IDLE;
          end
        end
        RWAIT: begin
          if (lat_cnt == 4'd1) begin
            state    <= RRESP;
            resp_vld <= 1'b1;
            resp_bus <= {1'b0, 3'b000, 1'b1, MY_ID, lat_src, 2'b11,
                         1'b0, 1'b1, 1'b1, lat_size, lat_addr, rd_data};
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RRESP: begin
          if (!bus.bus_gnt) begin
            state    <= IDLE;
            resp_vld <= 1'b0;
            resp_bus <= '0;
          end
        end
      endcase
    end
  end

  assign bus.o_vld  = resp_vld;
  assign bus.o_bus  = resp_bus;
  assign o_busy     = (state != IDLE);
  assign o_wr_cnt   = wr_cnt;
  assign o_drop_cnt = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_target.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_target : directed vector table plus hand sequences for stall,
//                     source collision, window boundary and reset
// Revision          : 1.0
// ============================================================================
module tb_mem_bus_target;
  localparam int RD_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] wr_cnt;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  mem_bus_if bif ();

  mem_bus_target #(
    .MY_ID    (2'b11),
    .MEM_BASE (15'h0000),
    .MEM_BYTES(4096),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .o_busy    (busy),
    .o_wr_cnt  (wr_cnt),
    .o_drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic [63:0] beat;
    logic        gnt;
    logic        vld;
    logic [63:0] rbus;
    logic        busy;
    logic [15:0] wr;
    logic [7:0]  drop;
  } vec_t;

  vec_t        tbl[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_wr;
  logic [7:0]  exp_drop;

  function automatic logic [63:0] beat(input logic [31:0] d, input logic [14:0] a,
                                       input logic [2:0] sz, input logic first,
                                       input logic [1:0] rw, input logic [1:0] dst,
                                       input logic [1:0] src);
    return {1'b0, 3'b000, 1'b1, src, dst, rw, 1'b0, first, 1'b1, sz, a, d};
  endfunction

  function automatic logic [63:0] resp(input logic [31:0] d, input logic [14:0] a,
                                       input logic [2:0] sz, input logic [1:0] dst);
    return {1'b0, 3'b000, 1'b1, 2'b11, dst, 2'b11, 1'b0, 1'b1, 1'b1, sz, a, d};
  endfunction

  function automatic logic [63:0] wh(input logic [14:0] a, input logic [2:0] sz,
                                     input logic [1:0] src);
    return beat(32'h0, a, sz, 1'b1, 2'b10, 2'b11, src);
  endfunction

  function automatic logic [63:0] wd(input logic [31:0] d, input logic [1:0] src);
    return beat(d, 15'h0, 3'd0, 1'b0, 2'b10, 2'b11, src);
  endfunction

  function automatic logic [63:0] rh(input logic [14:0] a, input logic [2:0] sz,
                                     input logic [1:0] src);
    return beat(32'h0, a, sz, 1'b1, 2'b01, 2'b11, src);
  endfunction

  function automatic vec_t mk(input logic r, input logic [63:0] b, input logic g,
                              input logic v, input logic [63:0] rb, input logic bz,
                              input logic [15:0] w, input logic [7:0] dr);
    vec_t t;
    t.rst_n = r; t.beat = b; t.gnt = g; t.vld = v;
    t.rbus = rb; t.busy = bz; t.wr = w; t.drop = dr;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [63:0] b, input logic g);
    @(negedge clk);
    rst         = r;
    bif.i_bus   = b;
    bif.bus_gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic v, input logic [63:0] rb,
                           input logic bz);
    chk({nm, "_vld"},  64'(bif.o_vld), 64'(v));
    chk({nm, "_bus"},  bif.o_bus, rb);
    chk({nm, "_busy"}, 64'(busy), 64'(bz));
    chk({nm, "_wr"},   64'(wr_cnt), 64'(exp_wr));
    chk({nm, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic do_read(input string nm, input logic [14:0] a, input logic [2:0] sz,
                         input logic [1:0] src, input logic [31:0] d);
    step(1'b1, rh(a, sz, src), 1'b1);
    chk_state({nm, "_acc"}, 1'b0, 64'h0, 1'b1);
    for (int k = 1; k < RD_LAT; k++) begin
      step(1'b1, 64'h0, 1'b1);
      chk_state({nm, "_wait"}, 1'b0, 64'h0, 1'b1);
    end
    step(1'b1, 64'h0, 1'b1);
    chk_state({nm, "_rsp"}, 1'b1, resp(d, a, sz, src), 1'b1);
    step(1'b1, 64'h0, 1'b0);
    chk_state({nm, "_done"}, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    rst         = 1'b0;
    bif.i_bus   = 64'h0;
    bif.bus_gnt = 1'b1;

    tbl.push_back(mk(0, 64'h0, 1, 0, 64'h0, 0, 0, 0));
    tbl.push_back(mk(0, 64'h0, 1, 0, 64'h0, 0, 0, 0));
    tbl.push_back(mk(1, wh(15'h0010, 3, 2'b01), 1, 0, 64'h0, 1, 0, 0));
    tbl.push_back(mk(1, wd(32'hA1B2C3D4, 2'b01), 1, 0, 64'h0, 0, 1, 0));
    tbl.push_back(mk(1, rh(15'h0010, 3, 2'b10), 1, 0, 64'h0, 1, 1, 0));
    tbl.push_back(mk(1, 64'h0, 1, 0, 64'h0, 1, 1, 0));
    tbl.push_back(mk(1, 64'h0, 1, 0, 64'h0, 1, 1, 0));
    tbl.push_back(mk(1, 64'h0, 1, 1, resp(32'hA1B2C3D4, 15'h0010, 3, 2'b10), 1, 1, 0));
    tbl.push_back(mk(1, 64'h0, 0, 0, 64'h0, 0, 1, 0));
    tbl.push_back(mk(1, wh(15'h0020, 7, 2'b01), 1, 0, 64'h0, 1, 1, 0));
    tbl.push_back(mk(1, wd(32'h04030201, 2'b01), 1, 0, 64'h0, 0, 2, 0));
    tbl.push_back(mk(1, rh(15'h0024, 3, 2'b01), 1, 0, 64'h0, 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 1, 0, 64'h0, 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 1, 0, 64'h0, 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 1, 1, resp(32'h04030201, 15'h0024, 3, 2'b01), 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 0, 0, 64'h0, 0, 2, 0));
    tbl.push_back(mk(1, rh(15'h0022, 3, 2'b10), 1, 0, 64'h0, 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 1, 0, 64'h0, 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 1, 0, 64'h0, 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 1, 1, resp(32'h02010403, 15'h0022, 3, 2'b10), 1, 2, 0));
    tbl.push_back(mk(1, 64'h0, 0, 0, 64'h0, 0, 2, 0));
    // Beats for another node, invalid beats and foreign interrupts are ignored.
    tbl.push_back(mk(1, beat(32'h0, 15'h0030, 3, 1, 2'b10, 2'b01, 2'b01), 1, 0, 64'h0, 0, 2, 0));
    tbl.push_back(mk(1, wh(15'h0030, 3, 2'b01) & ~(64'd1 << 59), 1, 0, 64'h0, 0, 2, 0));
    tbl.push_back(mk(1, beat(32'h0, 15'h0030, 3, 1, 2'b10, 2'b00, 2'b01) | (64'd1 << 63),
                     1, 0, 64'h0, 0, 2, 0));
    tbl.push_back(mk(1, wd(32'h0, 2'b01), 1, 0, 64'h0, 0, 2, 1));

    foreach (tbl[k]) begin
      step(tbl[k].rst_n, tbl[k].beat, tbl[k].gnt);
      exp_wr   = tbl[k].wr;
      exp_drop = tbl[k].drop;
      chk_state($sformatf("vec%0d", k), tbl[k].vld, tbl[k].rbus, tbl[k].busy);
    end

    // Response stall, with our beats dropped during RWAIT and RRESP.
    step(1'b1, rh(15'h0010, 3, 2'b10), 1'b1);
    chk_state("stall_acc", 1'b0, 64'h0, 1'b1);
    step(1'b1, wd(32'hDEAD, 2'b01), 1'b1);
    exp_drop = exp_drop + 8'd1;
    chk_state("stall_wdrop", 1'b0, 64'h0, 1'b1);
    step(1'b1, 64'h0, 1'b1);
    chk_state("stall_wait", 1'b0, 64'h0, 1'b1);
    step(1'b1, 64'h0, 1'b1);
    chk_state("stall_rsp", 1'b1, resp(32'hA1B2C3D4, 15'h0010, 3, 2'b10), 1'b1);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, (s == 2) ? rh(15'h0040, 3, 2'b01) : 64'h0, 1'b1);
      if (s == 2) exp_drop = exp_drop + 8'd1;
      chk_state($sformatf("stall_hold%0d", s), 1'b1,
                resp(32'hA1B2C3D4, 15'h0010, 3, 2'b10), 1'b1);
    end
    step(1'b1, 64'h0, 1'b0);
    chk_state("stall_done", 1'b0, 64'h0, 1'b0);

    // Competing header from another source mid-write.
    step(1'b1, wh(15'h0040, 3, 2'b01), 1'b1);
    chk_state("coll_hdr1", 1'b0, 64'h0, 1'b1);
    step(1'b1, wh(15'h0050, 3, 2'b10), 1'b1);
    exp_drop = exp_drop + 8'd1;
    chk_state("coll_hdr2", 1'b0, 64'h0, 1'b1);
    step(1'b1, wd(32'h00000011, 2'b01), 1'b1);
    exp_wr = exp_wr + 16'd1;
    chk_state("coll_data", 1'b0, 64'h0, 1'b0);
    do_read("coll_rd", 15'h0040, 3, 2'b01, 32'h00000011);

    // Window edge and 15-bit wrap.
    step(1'b1, wh(15'h0FFE, 3, 2'b01), 1'b1);
    step(1'b1, wd(32'hDDCCBBAA, 2'b01), 1'b1);
    exp_wr = exp_wr + 16'd1;
    chk_state("edge_wr", 1'b0, 64'h0, 1'b0);
    do_read("edge_rd", 15'h0FFE, 3, 2'b10, 32'h0000BBAA);
    step(1'b1, wh(15'h0000, 1, 2'b01), 1'b1);
    step(1'b1, wd(32'h00009988, 2'b01), 1'b1);
    exp_wr = exp_wr + 16'd1;
    chk_state("zero_wr", 1'b0, 64'h0, 1'b0);
    do_read("wrap_rd", 15'h7FFE, 3, 2'b01, 32'h00000000);

    // Reset during RWAIT abandons the read; RAM contents survive.
    step(1'b1, rh(15'h0020, 3, 2'b10), 1'b1);
    step(1'b1, 64'h0, 1'b1);
    step(1'b0, 64'h0, 1'b1);
    exp_wr   = 16'd0;
    exp_drop = 8'd0;
    chk_state("rst_mid", 1'b0, 64'h0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 64'h0, 1'b1);
      chk_state($sformatf("rst_after%0d", s), 1'b0, 64'h0, 1'b0);
    end
    do_read("rst_rd", 15'h0020, 3, 2'b10, 32'h04030201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
